// File: rtl/slice_progress_ctrl_if.sv
// Run-control handshake bundle between the key/engine side and the progress sequencer.
// The master drives key and slice pulses; the slave returns display events, count and engine enable.
interface slice_progress_ctrl_if;
   logic       start_key_i;
   logic       pause_key_i;
   logic       slice_done_i;
   logic       engine_en_o;
   logic       start_o;
   logic       pause_o;
   logic       finish_o;
   logic [4:0] slice_num_o;
   logic       busy_o;
   logic       timeout_o;

   modport master (
      output start_key_i, pause_key_i, slice_done_i,
      input  engine_en_o, start_o, pause_o, finish_o, slice_num_o, busy_o, timeout_o
   );

   modport slave (
      input  start_key_i, pause_key_i, slice_done_i,
      output engine_en_o, start_o, pause_o, finish_o, slice_num_o, busy_o, timeout_o
   );
endinterface

// File: rtl/slice_progress_ctrl.sv
// IDLE/RUN/PAUSE/DONE run sequencer: one-cycle registered latency, no backpressure (pulses are fire-and-forget).
// Optional RUN-time watchdog abort is built only when SLICE_TIMEOUT_EN is defined.
module slice_progress_ctrl #(
   parameter int NUM_SLICES     = 16,
   parameter int TIMEOUT_CYCLES = 50_000_000
) (
   input  logic                 clk,
   input  logic                 rst,
   slice_progress_ctrl_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

   localparam logic [4:0] LAST = 5'(NUM_SLICES);

   state_t     state_q, state_d;
   logic [4:0] cnt_q, cnt_d, cnt_inc;
   logic       start_q, start_d;
   logic       pause_q, pause_d;
   logic       finish_q, finish_d;
   logic       en_q, en_d;
   logic       busy_q, busy_d;
   logic       to_q, to_d;
   logic       abort;

`ifdef SLICE_TIMEOUT_EN
   localparam int             WD_W     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

   logic [WD_W-1:0] wd_q;
   logic            wd_clr;

   // Resuming from PAUSE is not a clear: paused cycles only push the abort out.
   assign wd_clr = start_d && (state_q != S_PAUSE) ||
                   bus.slice_done_i && (state_q == S_RUN || state_q == S_PAUSE);
   assign abort  = (state_q == S_RUN) && !bus.slice_done_i && (wd_q == WD_LIMIT);

   always_ff @(posedge clk) begin
      if (rst)
         wd_q <= '0;
      else if (wd_clr)
         wd_q <= '0;
      else if (state_q == S_RUN && wd_q != WD_LIMIT)
         wd_q <= wd_q + WD_W'(1);
   end
`else
   assign abort = 1'b0;
`endif

   assign cnt_inc = (cnt_q < LAST) ? cnt_q + 5'd1 : cnt_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      start_d  = 1'b0;
      pause_d  = 1'b0;
      finish_d = 1'b0;
      to_d     = to_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start_key_i) begin
               state_d = S_RUN;
               cnt_d   = '0;
               start_d = 1'b1;
            end
         end
         S_RUN, S_PAUSE: begin
            // The slice is counted before any key is considered, so completion outranks pause/resume.
            if (bus.slice_done_i)
               cnt_d = cnt_inc;
            if (bus.slice_done_i && cnt_inc == LAST) begin
               state_d  = S_DONE;
               finish_d = 1'b1;
            end else if (abort) begin
               state_d  = S_DONE;
               finish_d = 1'b1;
               to_d     = 1'b1;
            end else if (state_q == S_RUN && bus.pause_key_i) begin
               state_d = S_PAUSE;
               pause_d = 1'b1;
            end else if (state_q == S_PAUSE && (bus.start_key_i || bus.pause_key_i)) begin
               state_d = S_RUN;
               start_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (start_d)
         to_d = 1'b0;
      en_d   = (state_d == S_RUN);
      busy_d = (state_d == S_RUN) || (state_d == S_PAUSE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         start_q  <= 1'b0;
         pause_q  <= 1'b0;
         finish_q <= 1'b0;
         en_q     <= 1'b0;
         busy_q   <= 1'b0;
         to_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         start_q  <= start_d;
         pause_q  <= pause_d;
         finish_q <= finish_d;
         en_q     <= en_d;
         busy_q   <= busy_d;
         to_q     <= to_d;
      end
   end

   assign bus.engine_en_o = en_q;
   assign bus.start_o     = start_q;
   assign bus.pause_o     = pause_q;
   assign bus.finish_o    = finish_q;
   assign bus.slice_num_o = cnt_q;
   assign bus.busy_o      = busy_q;
   assign bus.timeout_o   = to_q;
endmodule

// File: tb/tb_slice_progress_ctrl.sv
// Scoreboarded bench for slice_progress_ctrl: a behavioural run model queues the expected outputs per cycle.
// Watchdog scenarios are compiled in only when SLICE_TIMEOUT_EN is defined.
module tb_slice_progress_ctrl;
   localparam int NS = 16;
   localparam int TO = 20;
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

   typedef struct packed {
      logic       en;
      logic       st;
      logic       pa;
      logic       fi;
      logic [4:0] num;
      logic       busy;
      logic       to;
   } obs_t;

   logic clk;
   logic rst;
   slice_progress_ctrl_if bus();

   slice_progress_ctrl #(.NUM_SLICES(NS), .TIMEOUT_CYCLES(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         n_run  = 0;
   int         n_fail = 0;
   obs_t       sb[$];
   obs_t       hist[$];
   logic [3:0] stim[$];   // {rst, start_key, pause_key, slice_done}

   int         m_state = M_IDLE;
   logic [4:0] m_cnt   = '0;
   logic       m_to    = 1'b0;
   int         m_wd    = 0;

   function automatic obs_t observe();
      return {bus.engine_en_o, bus.start_o, bus.pause_o, bus.finish_o,
              bus.slice_num_o, bus.busy_o, bus.timeout_o};
   endfunction

   // Reference run model: one call per clock, pushes the outputs expected after that edge.
   task automatic model_step(input logic [3:0] v);
      obs_t e;
      logic s, p, d, abort;
      int   prev;
      e = '0;
      s = v[2]; p = v[1]; d = v[0];
      abort = 1'b0;
      prev = m_state;
      if (v[3]) begin
         m_state = M_IDLE; m_cnt = '0; m_to = 1'b0; m_wd = 0;
      end else if (prev == M_IDLE || prev == M_DONE) begin
         if (s) begin
            m_state = M_RUN; m_cnt = '0; m_wd = 0; m_to = 1'b0; e.st = 1'b1;
         end
      end else begin
`ifdef SLICE_TIMEOUT_EN
         abort = (prev == M_RUN) && !d && (m_wd == TO);
         if (d) m_wd = 0;
         else if (prev == M_RUN && m_wd < TO) m_wd++;
`endif
         if (d && m_cnt < 5'(NS)) m_cnt = m_cnt + 5'd1;
         if (d && m_cnt == 5'(NS)) begin
            m_state = M_DONE; e.fi = 1'b1;
         end else if (abort) begin
            m_state = M_DONE; e.fi = 1'b1; m_to = 1'b1;
         end else if (prev == M_RUN && p) begin
            m_state = M_PAUSE; e.pa = 1'b1;
         end else if (prev == M_PAUSE && (s || p)) begin
            m_state = M_RUN; e.st = 1'b1; m_to = 1'b0;
         end
      end
      e.en   = (m_state == M_RUN);
      e.busy = (m_state == M_RUN) || (m_state == M_PAUSE);
      e.num  = m_cnt;
      e.to   = m_to;
      sb.push_back(e);
   endtask

   task automatic cycle(input logic [3:0] v);
      rst = v[3];
      bus.start_key_i  = v[2];
      bus.pause_key_i  = v[1];
      bus.slice_done_i = v[0];
      model_step(v);
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.start_key_i  = 1'b0;
      bus.pause_key_i  = 1'b0;
      bus.slice_done_i = 1'b0;
   endtask

   task automatic test_reset();
      obs_t got, exp;
      stim = '{4'b1000, 4'b1100, 4'b1010};
      hist.delete();
      for (int i = 0; i < stim.size(); i++) begin
         cycle(stim[i]); got = observe(); exp = sb.pop_front(); hist.push_back(got);
         n_run++;
         if (got !== exp) begin n_fail++; $display("FAIL reset step %0d: got %h want %h", i, got, exp); end
      end
      n_run++;
      if (hist[2] !== obs_t'(0)) begin n_fail++; $display("FAIL reset_zero: got %h want 0", hist[2]); end
   endtask

   task automatic test_full_run();
      obs_t got, exp;
      int   n_st;
      stim.delete(); hist.delete();
      stim.push_back(4'b0100);
      for (int k = 0; k < NS; k++) begin
         stim.push_back(4'b0001); stim.push_back(4'b0000); stim.push_back(4'b0000);
      end
      for (int i = 0; i < stim.size(); i++) begin
         cycle(stim[i]); got = observe(); exp = sb.pop_front(); hist.push_back(got);
         n_run++;
         if (got !== exp) begin n_fail++; $display("FAIL full_run step %0d: got %h want %h", i, got, exp); end
      end
      n_st = 0;
      foreach (hist[i]) if (hist[i].st) n_st++;
      n_run++;
      if (hist[0].st !== 1'b1 || n_st != 1) begin
         n_fail++; $display("FAIL full_run_start: start@0=%b count=%0d want 1 and 1", hist[0].st, n_st);
      end
      for (int k = 0; k < NS; k++) begin
         n_run++;
         if (hist[1 + 3*k].num !== 5'(k + 1)) begin
            n_fail++; $display("FAIL full_run_count %0d: got %0d want %0d", k, hist[1 + 3*k].num, k + 1);
         end
      end
      n_run++;
      if (hist[46].fi !== 1'b1 || hist[46].en !== 1'b0 || hist[46].busy !== 1'b0 || hist[45].fi !== 1'b0) begin
         n_fail++; $display("FAIL full_run_finish: got %h want fi=1 en=0 busy=0", hist[46]);
      end
   endtask

   task automatic test_pause();
      obs_t got, exp;
      stim.delete(); hist.delete();
      stim.push_back(4'b0100);
      repeat (5) stim.push_back(4'b0001);
      stim.push_back(4'b0010);
      stim.push_back(4'b0001);
      stim.push_back(4'b0010);
      repeat (9) stim.push_back(4'b0001);
      stim.push_back(4'b0011);
      for (int i = 0; i < stim.size(); i++) begin
         cycle(stim[i]); got = observe(); exp = sb.pop_front(); hist.push_back(got);
         n_run++;
         if (got !== exp) begin n_fail++; $display("FAIL pause step %0d: got %h want %h", i, got, exp); end
      end
      n_run++;
      if (hist[0].num !== 5'd0 || hist[6].pa !== 1'b1 || hist[6].en !== 1'b0 || hist[6].num !== 5'd5) begin
         n_fail++; $display("FAIL pause_enter: got %h want pa=1 en=0 num=5", hist[6]);
      end
      n_run++;
      if (hist[7].num !== 5'd6 || hist[7].busy !== 1'b1 || hist[7].en !== 1'b0) begin
         n_fail++; $display("FAIL pause_drain: got %h want num=6 busy=1 en=0", hist[7]);
      end
      n_run++;
      if (hist[8].st !== 1'b1 || hist[8].en !== 1'b1) begin
         n_fail++; $display("FAIL pause_resume: got %h want st=1 en=1", hist[8]);
      end
      n_run++;
      if (hist[18].fi !== 1'b1 || hist[18].pa !== 1'b0 || hist[18].num !== 5'd16 || hist[18].busy !== 1'b0) begin
         n_fail++; $display("FAIL pause_vs_finish: got %h want fi=1 pa=0 num=16", hist[18]);
      end
   endtask

   task automatic test_done_keys();
      obs_t got, exp;
      stim.delete(); hist.delete();
      stim = '{4'b0010, 4'b0001, 4'b0011, 4'b0100};
      repeat (15) stim.push_back(4'b0001);
      stim.push_back(4'b0010);
      stim.push_back(4'b0101);
      for (int i = 0; i < stim.size(); i++) begin
         cycle(stim[i]); got = observe(); exp = sb.pop_front(); hist.push_back(got);
         n_run++;
         if (got !== exp) begin n_fail++; $display("FAIL done_keys step %0d: got %h want %h", i, got, exp); end
      end
      n_run++;
      if (hist[2].num !== 5'd16 || hist[2].busy !== 1'b0 || hist[2].pa !== 1'b0) begin
         n_fail++; $display("FAIL done_ignore: got %h want num=16 idle", hist[2]);
      end
      n_run++;
      if (hist[3].num !== 5'd0 || hist[3].st !== 1'b1 || hist[3].en !== 1'b1) begin
         n_fail++; $display("FAIL done_restart: got %h want num=0 st=1 en=1", hist[3]);
      end
      n_run++;
      if (hist[20].fi !== 1'b1 || hist[20].st !== 1'b0 || hist[20].num !== 5'd16) begin
         n_fail++; $display("FAIL paused_finish_priority: got %h want fi=1 st=0", hist[20]);
      end
   endtask

   task automatic test_reset_mid_run();
      obs_t got, exp;
      stim.delete(); hist.delete();
      stim.push_back(4'b0100);
      repeat (9) stim.push_back(4'b0001);
      stim.push_back(4'b1100);
      stim.push_back(4'b0010);
      for (int i = 0; i < stim.size(); i++) begin
         cycle(stim[i]); got = observe(); exp = sb.pop_front(); hist.push_back(got);
         n_run++;
         if (got !== exp) begin n_fail++; $display("FAIL reset_mid step %0d: got %h want %h", i, got, exp); end
      end
      n_run++;
      if (hist[9].num !== 5'd9 || hist[10] !== obs_t'(0) || hist[11] !== obs_t'(0)) begin
         n_fail++; $display("FAIL reset_mid_zero: got %h then %h want 0", hist[10], hist[11]);
      end
   endtask

   task automatic test_back_to_back();
      obs_t got, exp;
      stim.delete(); hist.delete();
      stim.push_back(4'b0100);
      repeat (NS) stim.push_back(4'b0001);
      stim.push_back(4'b0001);
      for (int i = 0; i < stim.size(); i++) begin
         cycle(stim[i]); got = observe(); exp = sb.pop_front(); hist.push_back(got);
         n_run++;
         if (got !== exp) begin n_fail++; $display("FAIL back_to_back step %0d: got %h want %h", i, got, exp); end
      end
      n_run++;
      if (hist[8].num !== 5'd8 || hist[16].fi !== 1'b1 || hist[17].fi !== 1'b0 || hist[17].num !== 5'd16) begin
         n_fail++; $display("FAIL back_to_back_sat: got %h then %h want fi once, num=16", hist[16], hist[17]);
      end
   endtask

`ifdef SLICE_TIMEOUT_EN
   task automatic test_timeout();
      obs_t got, exp;
      stim.delete(); hist.delete();
      stim.push_back(4'b0100);
      repeat (24) stim.push_back(4'b0000);
      stim.push_back(4'b0100);
      repeat (9) stim.push_back(4'b0000);
      stim.push_back(4'b0010);
      repeat (4) stim.push_back(4'b0000);
      stim.push_back(4'b0100);
      repeat (20) stim.push_back(4'b0000);
      for (int i = 0; i < stim.size(); i++) begin
         cycle(stim[i]); got = observe(); exp = sb.pop_front(); hist.push_back(got);
         n_run++;
         if (got !== exp) begin n_fail++; $display("FAIL timeout step %0d: got %h want %h", i, got, exp); end
      end
      n_run++;
      if (hist[20].fi !== 1'b0 || hist[21].fi !== 1'b1 || hist[21].to !== 1'b1 || hist[24].to !== 1'b1) begin
         n_fail++; $display("FAIL timeout_abort: got %h at 21 want fi=1 to=1", hist[21]);
      end
      n_run++;
      if (hist[25].to !== 1'b0 || hist[25 + 10].pa !== 1'b1 || hist[25 + 15].st !== 1'b1) begin
         n_fail++; $display("FAIL timeout_pause_setup: got %h at resume want st=1 to=0", hist[40]);
      end
      n_run++;
      if (hist[25 + 25].fi !== 1'b0 || hist[25 + 26].fi !== 1'b1 || hist[25 + 26].to !== 1'b1) begin
         n_fail++; $display("FAIL timeout_extended: got %h at 51 want fi=1 to=1", hist[51]);
      end
   endtask
`endif

   initial begin
      rst = 1'b1;
      bus.start_key_i  = 1'b0;
      bus.pause_key_i  = 1'b0;
      bus.slice_done_i = 1'b0;
      test_reset();
      test_full_run();
      test_pause();
      test_done_keys();
      test_reset_mid_run();
      test_back_to_back();
`ifdef SLICE_TIMEOUT_EN
      test_reset();
      test_timeout();
`endif
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
